// File: rtl/spi_slv_pkg.sv
// Shared definitions for the SPI burst slave: FSM state encoding and the 2-bit command codes.
package spi_slv_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      PAYLOAD = 3'd2,
      WAIT_TX = 3'd3,
      TX      = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_burst_if.sv
// Serial pins plus the word-side handshake of the SPI burst slave, grouped for the slave and its driver.
interface spi_slave_burst_if #(
   parameter int DATA_W = 8
);
   logic              SS_n;
   logic              MOSI;
   logic              MISO;
   logic [DATA_W+1:0] rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              busy;
   logic              frame_err;

   modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                   output MISO, rx_data, rx_valid, busy, frame_err);
   modport master (output SS_n, MOSI, tx_data, tx_valid,
                   input  MISO, rx_data, rx_valid, busy, frame_err);
endinterface

// File: rtl/spi_slv_shifter.sv
// DATA_W-bit shift register with bit counter, shared by the receive (SIPO) and transmit (PISO) phases.
module spi_slv_shifter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift,
   input  logic              sin,
   output logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  cnt
);
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (load) begin
         // The word's MSB goes out on the load edge itself, so one bit is already counted.
         data_d = load_data;
         cnt_d  = CNT_W'(1);
      end else if (shift) begin
         data_d = {data_q[DATA_W-2:0], sin};
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data = data_q;
   assign cnt  = cnt_q;
endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave decoding {cmd, payload} frames and streaming read data on MISO.
// Define SPI_SLV_BURST_EN to allow several frames/words per SS_n assertion.
module spi_slave_burst
   import spi_slv_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_slave_burst_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

   state_t            state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic              miso_q, miso_d;
   logic [DATA_W+1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;

   logic              sh_clr, sh_load, sh_shift, sh_sin;
   logic [DATA_W-1:0] sh_data;
   logic [CNT_W-1:0]  sh_cnt;
   logic              frame_complete;

   spi_slv_shifter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (sh_clr),
      .load      (sh_load),
      .load_data ({bus.tx_data[DATA_W-2:0], 1'b0}),
      .shift     (sh_shift),
      .sin       (sh_sin),
      .data      (sh_data),
      .cnt       (sh_cnt)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      sh_clr      = 1'b0;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;
      sh_sin      = bus.MOSI;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            sh_clr = 1'b1;
            if (!bus.SS_n) state_d = CMD;
         end
         CMD: begin
            sh_shift = 1'b1;
            if (sh_cnt == CNT_ONE) begin
               cmd_d   = {sh_data[0], bus.MOSI};
               sh_clr  = 1'b1;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            sh_shift = 1'b1;
            if (sh_cnt == CNT_LAST) begin
               rx_data_d  = {cmd_q, sh_data[DATA_W-2:0], bus.MOSI};
               rx_valid_d = 1'b1;
               sh_clr     = 1'b1;
`ifdef SPI_SLV_BURST_EN
               state_d = (cmd_q == CMD_RD_DATA) ? WAIT_TX : PAYLOAD;
`else
               state_d = (cmd_q == CMD_RD_DATA) ? WAIT_TX : DONE;
`endif
            end
         end
         WAIT_TX: begin
            miso_d = 1'b0;
            if (bus.tx_valid) begin
               sh_load = 1'b1;
               miso_d  = bus.tx_data[DATA_W-1];
               state_d = TX;
            end
         end
         TX: begin
            if (sh_cnt == CNT_FULL) begin
               miso_d = 1'b0;
               sh_clr = 1'b1;
`ifdef SPI_SLV_BURST_EN
               state_d = WAIT_TX;
`else
               state_d = DONE;
`endif
            end else begin
               // The shifter holds the remaining bits pre-aligned, so its MSB is the next MISO bit.
               miso_d   = sh_data[DATA_W-1];
               sh_shift = 1'b1;
               sh_sin   = 1'b0;
            end
         end
         DONE:    miso_d  = 1'b0;
         default: state_d = IDLE;
      endcase

      // Deselect wins over everything except a frame finishing on this very edge.
      if (bus.SS_n && state_q != IDLE) begin
         frame_err_d = (state_q == CMD || state_q == PAYLOAD || state_q == TX) &&
                       (sh_cnt != '0) && !frame_complete;
         state_d     = IDLE;
         miso_d      = 1'b0;
         sh_clr      = 1'b1;
         sh_load     = 1'b0;
      end
   end

   assign frame_complete = rx_valid_d || (state_q == TX && sh_cnt == CNT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.MISO      = miso_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state_q != IDLE);
endmodule
